// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: the glyph table,
// the scan FSM state encoding and the default digit count.
package seg7_pkg;

  localparam int DEFAULT_NUM_DIGITS = 6;

  // Active-low segment patterns, bit order g..a, indexed by hex value
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_unhex.sv
// Maps an active-low 7-segment pattern back to its hex nibble; anything not
// in the glyph table decodes to 0 with the illegal flag raised.
module seg7_unhex
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_nibble,
  output logic       o_illegal
);

  logic [15:0] w_hit;

  // Table lookup: glyphs are unique, so OR-ing the matching index is exact
  always_comb begin
    w_hit    = 16'h0000;
    o_nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      w_hit[i] = (i_pattern == GLYPH_TABLE[i]);
      o_nibble = o_nibble | (w_hit[i] ? 4'(i) : 4'h0);
    end
    o_illegal = (w_hit == 16'h0000);
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed 7-segment display bus, waits for each digit's pattern
// to settle, and emits one decoded event per settled digit via valid/ready.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = DEFAULT_NUM_DIGITS,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_digit,
  output logic [3:0]              out_nibble,
  output logic                    out_err,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    overflow
);

  localparam logic [7:0]            STABLE_M1 = 8'(STABLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_D     = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] ZERO_D    = {NUM_DIGITS{1'b0}};

  function automatic logic [2:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      idx = idx | (v[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

  logic [6:0]            r_seg_meta, r_seg_sync, r_prev_seg;
  logic [NUM_DIGITS-1:0] r_dig_meta, r_dig_sync, r_prev_dig;
  state_t                r_state, w_next_state;
  logic [7:0]            r_cnt, w_next_cnt;
  logic                  r_evt, w_evt_set;
  logic                  w_onehot, w_same;
  logic [3:0]            w_nibble;
  logic                  w_illegal;
  logic [2:0]            w_evt_idx;

  assign w_onehot  = (r_dig_sync != ZERO_D) && ((r_dig_sync & (r_dig_sync - ONE_D)) == ZERO_D);
  assign w_same    = (r_seg_sync == r_prev_seg) && (r_dig_sync == r_prev_dig);
  assign w_evt_idx = onehot_idx(r_prev_dig);

  // The event pulse lags the lock by one cycle, so r_prev_* still holds the locked pair
  seg7_unhex u_unhex (
    .i_pattern (r_prev_seg),
    .o_nibble  (w_nibble),
    .o_illegal (w_illegal)
  );

  // Input synchronizers, previous-pair history and scan FSM state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg_meta <= 7'd0;
      r_seg_sync <= 7'd0;
      r_dig_meta <= ZERO_D;
      r_dig_sync <= ZERO_D;
      r_prev_seg <= 7'd0;
      r_prev_dig <= ZERO_D;
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_evt      <= 1'b0;
    end else begin
      r_seg_meta <= seg_n;
      r_seg_sync <= r_seg_meta;
      r_dig_meta <= dig_sel;
      r_dig_sync <= r_dig_meta;
      r_prev_seg <= r_seg_sync;
      r_prev_dig <= r_dig_sync;
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_evt      <= w_evt_set;
    end
  end

  // Next-state logic: count consecutive identical pairs, fire once on lock
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_evt_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_onehot) begin
          w_next_state = ST_SETTLE;
          w_next_cnt   = 8'd1;
        end else begin
          w_next_cnt   = 8'd0;
        end
      end
      ST_SETTLE: begin
        if (!w_same) begin
          w_next_state = w_onehot ? ST_SETTLE : ST_IDLE;
          w_next_cnt   = w_onehot ? 8'd1 : 8'd0;
        end else if (r_cnt == STABLE_M1) begin
          w_next_state = ST_LOCKED;
          w_next_cnt   = r_cnt + 8'd1;
          w_evt_set    = 1'b1;
        end else begin
          w_next_cnt   = r_cnt + 8'd1;
        end
      end
      ST_LOCKED: begin
        if (!w_same) begin
          w_next_state = w_onehot ? ST_SETTLE : ST_IDLE;
          w_next_cnt   = w_onehot ? 8'd1 : 8'd0;
        end else begin
          w_next_state = ST_LOCKED;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 8'd0;
      end
    endcase
  end

  // Single-entry output holding register; an event during a transfer refills it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_digit  <= 3'd0;
      out_nibble <= 4'd0;
      out_err    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (r_evt && (!out_valid || out_ready)) begin
        out_valid  <= 1'b1;
        out_digit  <= w_evt_idx;
        out_nibble <= w_nibble;
        out_err    <= w_illegal;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
      if (r_evt && out_valid && !out_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // Per-digit shadow of the last decode, updated whether or not the event is consumed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits   <= {(4*NUM_DIGITS){1'b0}};
      err_mask <= ZERO_D;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (r_evt && r_prev_dig[i]) begin
          digits[4*i +: 4] <= w_nibble;
          err_mask[i]      <= w_illegal;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with hand-computed expectations.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  localparam int ND = 6;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [6:0]    seg_n = 7'b1111111;
  logic [ND-1:0] dig_sel = 6'b000000;
  logic          out_ready = 1'b0;
  logic          out_valid, out_err, overflow;
  logic [2:0]    out_digit;
  logic [3:0]    out_nibble;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] err_mask;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .reset_n(reset_n), .seg_n(seg_n), .dig_sel(dig_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_nibble(out_nibble), .out_err(out_err), .digits(digits),
    .err_mask(err_mask), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_event(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int cnt;
    int locked_cnt;
    logic [6:0] tog;

    // reset state
    step(); step();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", {21'd0, out_digit, out_nibble, out_err, overflow, 2'b00}, 32'd0);
    check_eq("rst_digits", 32'(digits), 32'd0);
    check_eq("rst_errmask", 32'(err_mask), 32'd0);
    check_eq("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    step();

    // digit 0 shows '3': exactly one event, visible after edge 6
    dig_sel = 6'b000001; seg_n = 7'b0110000; out_ready = 1'b1;
    cnt = 0;
    for (int e = 0; e < 10; e++) begin
      step();
      if (out_valid) cnt++;
      if (e == 5) check_eq("t1_not_yet", 32'(out_valid), 32'd0);
      if (e == 6) begin
        check_eq("t1_valid", 32'(out_valid), 32'd1);
        check_eq("t1_digit", 32'(out_digit), 32'd0);
        check_eq("t1_nibble", 32'(out_nibble), 32'h3);
        check_eq("t1_err", 32'(out_err), 32'd0);
        check_eq("t1_digits", 32'(digits[3:0]), 32'h3);
      end
    end
    check_eq("t1_one_event", 32'(cnt), 32'd1);

    // illegal pattern on digit 2, then legal 'A' clears the flag
    out_ready = 1'b0;
    dig_sel = 6'b000100; seg_n = 7'b1111111;
    wait_event("t2_evt_timeout");
    check_eq("t2_digit", 32'(out_digit), 32'd2);
    check_eq("t2_nibble", 32'(out_nibble), 32'h0);
    check_eq("t2_err", 32'(out_err), 32'd1);
    check_eq("t2_errmask", 32'(err_mask), 32'b000100);
    out_ready = 1'b1;
    step();
    check_eq("t2_drained", 32'(out_valid), 32'd0);
    seg_n = 7'b0001000;
    wait_event("t2b_evt_timeout");
    check_eq("t2b_nibble", 32'(out_nibble), 32'hA);
    check_eq("t2b_err", 32'(out_err), 32'd0);
    check_eq("t2b_errmask", 32'(err_mask), 32'd0);
    check_eq("t2b_digits", 32'(digits[11:8]), 32'hA);

    // pattern changing every 3 cycles never settles
    dig_sel = 6'b000001; tog = 7'b1111001;
    cnt = 0; locked_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      if (k % 3 == 0) begin
        tog = (tog == 7'b1111001) ? 7'b0100100 : 7'b1111001;
        seg_n = tog;
      end
      step();
      if (out_valid) cnt++;
      if (k >= 2 && dut.r_state != ST_SETTLE) locked_cnt++;
    end
    check_eq("t3_no_event", 32'(cnt), 32'd0);
    check_eq("t3_settle_only", 32'(locked_cnt), 32'd0);

    // two digits enabled at once is never one-hot
    dig_sel = 6'b000011; seg_n = 7'b0110000;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (out_valid) cnt++;
    end
    check_eq("t4_no_event", 32'(cnt), 32'd0);
    check_eq("t4_idle", 32'(dut.r_state), 32'(ST_IDLE));
    check_eq("t4_no_ovf", 32'(overflow), 32'd0);

    // backpressure: second event dropped, third loads during transfer
    out_ready = 1'b0;
    dig_sel = 6'b000010; seg_n = 7'b0100100;
    wait_event("t5_evt_timeout");
    check_eq("t5_first", {24'd0, 1'b0, out_digit, out_nibble}, {24'd0, 4'd1, 4'h2});
    dig_sel = 6'b001000; seg_n = 7'b0010010;
    for (int k = 0; k < 10; k++) step();
    check_eq("t5_held", {24'd0, out_valid, out_digit, out_nibble}, {24'd0, 4'b1001, 4'h2});
    check_eq("t5_overflow", 32'(overflow), 32'd1);
    check_eq("t5_digits", 32'(digits[15:12]), 32'h5);
    dig_sel = 6'b010000; seg_n = 7'b0000110;
    for (int e = 0; e < 6; e++) step();
    check_eq("t5_still_first", {28'd0, out_nibble}, 32'h2);
    out_ready = 1'b1;
    step();
    check_eq("t5_third_valid", 32'(out_valid), 32'd1);
    check_eq("t5_third", {24'd0, 1'b0, out_digit, out_nibble}, {24'd0, 4'd4, 4'hE});
    step();
    check_eq("t5_third_gone", 32'(out_valid), 32'd0);

    // async reset mid-settle with a held event
    out_ready = 1'b0;
    dig_sel = 6'b000001; seg_n = 7'b1111001;
    wait_event("t6_evt_timeout");
    seg_n = 7'b1111000;
    step(); step(); step();
    check_eq("t6_pre_settle", 32'(dut.r_state), 32'(ST_SETTLE));
    check_eq("t6_pre_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_rst_outs", {24'd0, out_valid, out_digit, out_nibble}, 32'd0);
    check_eq("t6_rst_flags", {30'd0, out_err, overflow}, 32'd0);
    check_eq("t6_rst_digits", 32'(digits), 32'd0);
    check_eq("t6_rst_errmask", 32'(err_mask), 32'd0);
    step(); step();
    out_ready = 1'b1;
    reset_n = 1'b1;
    cnt = 0;
    for (int e = 0; e < 7; e++) begin
      step();
      if (e < 6 && out_valid) cnt++;
      if (e == 6) check_eq("t6_post_valid", 32'(out_valid), 32'd1);
    end
    check_eq("t6_no_early", 32'(cnt), 32'd0);
    check_eq("t6_post_nibble", 32'(out_nibble), 32'h7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
